// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8-bit UART receiver, optional even parity via UART_RX_PARITY_EN
module uart_rx #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD       = 57600
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t             r_state;
    logic [1:0]         r_sync;
    logic               r_rx_prev;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               w_rx_s;
    logic               w_half_done;
    logic               w_bit_done;

    assign w_rx_s      = r_sync[1];
    assign w_half_done = (r_cnt == CNT_W'(HALF_BIT - 1));
    assign w_bit_done  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Two-flop synchronizer plus a delayed copy for start-edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_rx_prev <= w_rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;

    // Receive FSM with registered outputs; parity bit checked against even parity of the byte
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'h00;
            r_par_bad  <= 1'b0;
            data       <= 8'h00;
            valid      <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (r_rx_prev && !w_rx_s) begin
                        r_state   <= S_START;
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        busy      <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_half_done) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    if (w_bit_done) begin
                        r_cnt     <= '0;
                        r_par_bad <= (w_rx_s != ^r_shift);
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        if (w_rx_s) begin
                            data       <= r_shift;
                            valid      <= 1'b1;
                            parity_err <= r_par_bad;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
`else
    assign parity_err = 1'b0;

    // Receive FSM with registered outputs; stop bit follows data bit 7 directly
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (r_rx_prev && !w_rx_s) begin
                        r_state   <= S_START;
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        busy      <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_half_done) begin
                        r_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        if (w_rx_s) begin
                            data  <= r_shift;
                            valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLOCK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 57600, serial bit rate in bits/s.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 rx  input  1  asynchronous serial line, idle high.
REQ-006 data  output  8  last correctly framed received byte.
REQ-007 valid  output  1  one-cycle pulse: data updated with a new byte.
REQ-008 busy  output  1  high while a frame is being received.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 parity_err  output  1  one-cycle pulse: parity mismatch (see Configuration).

Function
REQ-011 CLKS_PER_BIT SHALL be CLOCK_FREQ/BAUD with integer truncation (1736 at defaults); HALF_BIT SHALL be CLKS_PER_BIT/2 (868).
REQ-012 rx SHALL pass through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value rx_s.
REQ-013 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is reachable only when the parity feature is compiled in.
REQ-015 IDLE: on rx_s high-to-low transition, load the bit counter and go to START; no other transition.
REQ-016 START: after HALF_BIT cycles sample rx_s; if 0 go to DATA, if 1 (glitch) return to IDLE with no output pulse.
REQ-017 DATA: sample rx_s every CLKS_PER_BIT cycles, shifting into bit index 0..7; after bit 7 go to PARITY (if enabled) else STOP.
REQ-018 STOP: sample rx_s CLKS_PER_BIT cycles after the last data/parity sample, then return to IDLE in the same cycle.
REQ-019 Stop sample 1: data SHALL load the shift register and valid SHALL pulse high for exactly one cycle on that edge.
REQ-020 Stop sample 0: frame_err SHALL pulse one cycle, valid SHALL stay low, data SHALL keep its previous value.
REQ-021 busy SHALL be high in START, DATA, PARITY and STOP, low in IDLE, including the glitch-abort cycle onward.
REQ-022 Back-to-back frames: a start edge arriving immediately after the stop-bit midpoint SHALL be detected with no lost frame.
REQ-023 Latency from rx pin falling edge to valid SHALL be 9.5*CLKS_PER_BIT + 3 cycles, +/-1 cycle (10.5*CLKS_PER_BIT with parity).
REQ-024 valid, frame_err and parity_err SHALL never be high for two consecutive cycles.

Reset
REQ-025 rstn low SHALL asynchronously force state IDLE, counters 0, shift register 0, synchronizer flops 1.
REQ-026 Reset values: data=8'h00, valid=0, busy=0, frame_err=0, parity_err=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release the partial frame SHALL produce no pulse, and the next full frame is received normally.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: frame includes an even-parity bit after bit 7; PARITY state samples it; mismatch pulses parity_err in the same cycle as valid; data still updates.
REQ-029 UART_RX_PARITY_EN undefined: no parity bit expected, PARITY state and parity logic absent, parity_err tied 0.

Verification
REQ-030 Defaults, frame 0x48 ('H') at 17360 ns/bit -> one valid pulse, data=0x48, frame_err=0, busy high for the frame.
REQ-031 Back-to-back 0x48 then 0x49 ('I'), single stop bit, no idle gap -> two valid pulses, data 0x48 then 0x49.
REQ-032 500 ns low glitch on idle rx -> busy returns low after HALF_BIT, no valid, no frame_err; following 0x55 received correctly.
REQ-033 0x55 with stop bit forced 0 after prior byte 0x48 -> frame_err pulse, no valid, data stays 0x48.
REQ-034 rstn pulsed low during bit 4 of 0xA5, then full 0x3C -> data=0x00 and outputs low after reset, then one valid with data=0x3C.
REQ-035 With UART_RX_PARITY_EN: 0x48 with parity 0 -> valid, parity_err=0; 0x48 with parity 1 -> valid and parity_err pulse same cycle.
